led_pattern_ctl: RTL
====================

# led_pattern_ctl

Parametrised multi-channel LED pattern engine, the successor to the fixed two-LED red/green select in the flasher top level. It drives NUM_LEDS outputs, each with its own mode (off, on, blink, alternate, breathe) and PWM brightness level, all sharing one prescaled time base. Channel registers are written from the I2C/Wishbone control path (pifctl write strobe/address/data) and can be read back. It sits between pifctl and the LED output buffers.

## Interface

Parameters:
- NUM_LEDS, 2, number of LED channels (1..16)
- PWM_BITS, 8, PWM counter and level width (1..8)
- PRE_BITS, 16, prescaler width; one pattern tick every 2^PRE_BITS clocks

Ports:
- xclk  in  1  system clock
- sys_rst  in  1  reset, asynchronous, active-low
- wr  in  1  single-cycle write strobe
- wr_addr  in  5  write address: [4:1] channel, [0] register (0 = mode, 1 = level)
- wr_data  in  8  write data
- rd_addr  in  5  read address, same map
- rd_data  out  8  registered read data
- led  out  NUM_LEDS  LED drive, 1 = lit
- tick  out  1  one-cycle pulse at each prescaler wrap

## Operation

- Per channel: mode[2:0] and level[PWM_BITS-1:0]. Mode write takes wr_data[2:0]; level write takes wr_data[PWM_BITS-1:0].
- Mode encoding: 0 OFF, 1 ON, 2 BLINK, 3 ALT, 4 BREATHE; 5..7 behave as OFF but read back as written.
- Shared time base:
  - pre_cnt counts up every clock and wraps; tick = 1 in the cycle pre_cnt == all-ones.
  - pwm_cnt counts up every clock and wraps.
  - phase toggles on each tick.
  - ramp (PWM_BITS wide) is a triangle generator stepping ±1 per tick. Up direction: 0 → max, then reverse. Down direction: max → 0, then reverse. Neither endpoint repeats.
- PWM gate: pwm_on(d) = (d > pwm_cnt). So level 0 is always dark; max level gives (2^PWM_BITS−1)/2^PWM_BITS duty.
- Per-mode output:
  - OFF: 0.
  - ON: pwm_on(level).
  - BLINK: phase & pwm_on(level).
  - ALT: (phase ^ ch[0]) & pwm_on(level), so even and odd channels are in antiphase.
  - BREATHE: pwm_on(ramp), scaled by nothing (level ignored).
- Writes to channel ≥ NUM_LEDS are ignored. Reads of channel ≥ NUM_LEDS return 0. Unused rd_data bits read 0.
- Mode/level changes never reset pre_cnt, pwm_cnt, phase or ramp; all channels stay phase-locked.

## Timing

- Reset values: mode = OFF, level = all-ones, pre_cnt = pwm_cnt = ramp = 0, phase = 0, ramp direction = up, led = 0, tick = 0, rd_data = 0.
- led is registered: a write at cycle N is first reflected on led at N+2 (register update at N+1 edge, led at N+2 edge).
- rd_data is registered: rd_addr sampled at edge N appears after that edge. A read of a register written in the same cycle returns the old value; the new value is visible the following cycle.
- tick is registered and high exactly one cycle per 2^PRE_BITS clocks. phase and ramp update on the edge ending the tick cycle.
- Write and tick in the same cycle: both take effect; no priority conflict.
- Asynchronous reset mid-pattern: all state returns to reset values immediately. After release, the first tick occurs 2^PRE_BITS clocks later.

## Structure

- Mode encodings LED_MODE_OFF/ON/BLINK/ALT/BREATHE and address field positions go in pifdefs.v alongside the existing LED_* defines.
- Sub-module led_pwm_chan, instantiated NUM_LEDS times via generate:
  - holds mode/level registers and the output flop;
  - inputs: shared pwm_cnt, phase, ramp, channel-select write enable.
- Top holds prescaler, pwm_cnt, phase, ramp, address decode and the read mux.

## Test plan

- Reset: assert sys_rst low mid-operation → led = 0, rd_data = 0, tick = 0 immediately. Read back mode = 0, level = 0xFF for every channel.
- ON/PWM: PWM_BITS = 8, ch0 mode 1, level 0x40 → led[0] high exactly 64 of every 256 clocks. Level 0 → never high.
- BLINK/ALT: PRE_BITS = 4, ch0 BLINK, ch1 ALT, level 0xFF → both toggle every 16 clocks in antiphase (ch1 lit when ch0 dark, excluding PWM gaps).
- BREATHE: PRE_BITS = 2, PWM_BITS = 3 → ramp sequence 0,1,…,7,6,…,0,1 per tick; led duty tracks ramp/8.
- Address bounds: NUM_LEDS = 2, write to channel 5 → no register changes. Read of channel 5 → 0. Write at cycle N, read same address at cycle N → old value; at cycle N+1 → new value.
- Collision: write ch0 mode = BLINK in the tick cycle → mode applied and phase toggles on the same edge; led[0] follows the new phase at N+2.

Source files
------------

// File: rtl/led_pattern_ctl_pkg.sv
// led_pattern_ctl_pkg: shared mode encodings, register map fields and ramp direction type.
`default_nettype none

package led_pattern_ctl_pkg;

  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 8;
  localparam int MODE_W       = 3;
  localparam int ADDR_REG_BIT = 0;
  localparam int ADDR_CH_LSB  = 1;
  localparam int ADDR_CH_MSB  = 4;
  localparam int CH_W         = ADDR_CH_MSB - ADDR_CH_LSB + 1;

  typedef logic [MODE_W-1:0] led_mode_t;

  localparam led_mode_t LED_MODE_OFF     = 3'd0;
  localparam led_mode_t LED_MODE_ON      = 3'd1;
  localparam led_mode_t LED_MODE_BLINK   = 3'd2;
  localparam led_mode_t LED_MODE_ALT     = 3'd3;
  localparam led_mode_t LED_MODE_BREATHE = 3'd4;

  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } ramp_dir_e;

endpackage

`default_nettype wire

// File: rtl/led_pwm_chan.sv
// led_pwm_chan: one LED channel - mode/level registers and the registered LED drive.
`default_nettype none

module led_pwm_chan
  import led_pattern_ctl_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int CH_IDX   = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we_mode,
  input  logic                i_we_level,
  input  led_mode_t           i_mode_data,
  input  logic [PWM_BITS-1:0] i_level_data,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic                i_phase,
  input  logic [PWM_BITS-1:0] i_ramp,
  output led_mode_t           o_mode,
  output logic [PWM_BITS-1:0] o_level,
  output logic                o_led
);

  // Odd channels run ALT in antiphase to even ones.
  localparam logic c_odd = CH_IDX[0];

  led_mode_t           r_mode;
  logic [PWM_BITS-1:0] r_level;
  logic                r_led;
  logic                w_level_on;
  logic                w_ramp_on;
  logic                w_led_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode  <= LED_MODE_OFF;
      r_level <= '1;
    end else begin
      if (i_we_mode)  r_mode  <= i_mode_data;
      if (i_we_level) r_level <= i_level_data;
    end
  end

  always_comb begin
    w_level_on = (r_level > i_pwm_cnt);
    w_ramp_on  = (i_ramp > i_pwm_cnt);
    w_led_next = 1'b0;
    case (r_mode)
      LED_MODE_ON:      w_led_next = w_level_on;
      LED_MODE_BLINK:   w_led_next = i_phase & w_level_on;
      LED_MODE_ALT:     w_led_next = (i_phase ^ c_odd) & w_level_on;
      LED_MODE_BREATHE: w_led_next = w_ramp_on;
      default:          w_led_next = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_led <= 1'b0;
    else          r_led <= w_led_next;
  end

  assign o_mode  = r_mode;
  assign o_level = r_level;
  assign o_led   = r_led;

endmodule

`default_nettype wire

// File: rtl/led_pattern_ctl.sv
// led_pattern_ctl: multi-channel LED pattern engine with a shared prescaled time base.
`default_nettype none

module led_pattern_ctl
  import led_pattern_ctl_pkg::*;
#(
  parameter int NUM_LEDS = 2,
  parameter int PWM_BITS = 8,
  parameter int PRE_BITS = 16
) (
  input  logic                xclk,
  input  logic                sys_rst,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic [NUM_LEDS-1:0] led,
  output logic                tick
);

  localparam logic [PRE_BITS-1:0] c_pre_last = '1;
  localparam logic [PRE_BITS-1:0] c_pre_tick = c_pre_last - PRE_BITS'(1);
  localparam logic [PWM_BITS-1:0] c_ramp_max = '1;

  logic [PRE_BITS-1:0] r_pre_cnt;
  logic                r_tick;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_phase;
  logic [PWM_BITS-1:0] r_ramp;
  ramp_dir_e           r_ramp_dir;
  logic [DATA_W-1:0]   r_rd_data;

  logic [CH_W-1:0]     w_wr_ch;
  logic [CH_W-1:0]     w_rd_ch;
  logic [DATA_W-1:0]   w_rd_data;
  led_mode_t           w_mode  [NUM_LEDS];
  logic [PWM_BITS-1:0] w_level [NUM_LEDS];

  // tick is registered, so it is raised one count early to land on the all-ones cycle.
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_pre_cnt <= '0;
      r_tick    <= 1'b0;
      r_pwm_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + PRE_BITS'(1);
      r_tick    <= (r_pre_cnt == c_pre_tick);
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

  // Triangle ramp: endpoints are visited once, direction flips on arrival.
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_phase    <= 1'b0;
      r_ramp     <= '0;
      r_ramp_dir <= RAMP_UP;
    end else if (r_tick) begin
      r_phase <= ~r_phase;
      if (r_ramp_dir == RAMP_UP) begin
        if (r_ramp == c_ramp_max) begin
          r_ramp_dir <= RAMP_DOWN;
          r_ramp     <= r_ramp - PWM_BITS'(1);
        end else begin
          r_ramp <= r_ramp + PWM_BITS'(1);
        end
      end else begin
        if (r_ramp == '0) begin
          r_ramp_dir <= RAMP_UP;
          r_ramp     <= r_ramp + PWM_BITS'(1);
        end else begin
          r_ramp <= r_ramp - PWM_BITS'(1);
        end
      end
    end
  end

  assign w_wr_ch = wr_addr[ADDR_CH_MSB:ADDR_CH_LSB];
  assign w_rd_ch = rd_addr[ADDR_CH_MSB:ADDR_CH_LSB];

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
    logic w_sel;
    assign w_sel = wr && (w_wr_ch == CH_W'(g));

    led_pwm_chan #(
      .PWM_BITS (PWM_BITS),
      .CH_IDX   (g)
    ) u_chan (
      .i_clk        (xclk),
      .i_rst_n      (sys_rst),
      .i_we_mode    (w_sel & ~wr_addr[ADDR_REG_BIT]),
      .i_we_level   (w_sel & wr_addr[ADDR_REG_BIT]),
      .i_mode_data  (wr_data[MODE_W-1:0]),
      .i_level_data (wr_data[PWM_BITS-1:0]),
      .i_pwm_cnt    (r_pwm_cnt),
      .i_phase      (r_phase),
      .i_ramp       (r_ramp),
      .o_mode       (w_mode[g]),
      .o_level      (w_level[g]),
      .o_led        (led[g])
    );
  end

  // Channels with no matching index fall through to zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (w_rd_ch == CH_W'(i)) begin
        w_rd_data = rd_addr[ADDR_REG_BIT] ? DATA_W'(w_level[i]) : DATA_W'(w_mode[i]);
      end
    end
  end

  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) r_rd_data <= '0;
    else          r_rd_data <= w_rd_data;
  end

  assign rd_data = r_rd_data;
  assign tick    = r_tick;

endmodule

`default_nettype wire
